// File: rtl/seq_divider_pkg.sv
// Shared widths and FSM encoding for the sequential restoring divider.
package seq_divider_pkg;

   localparam int unsigned DIVIDEND_W_DEF = 17;
   localparam int unsigned DIVISOR_W_DEF  = 8;
   localparam int unsigned CNT_W          = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int unsigned DIVISOR_W = DIVISOR_W_DEF
) (
   input  logic [DIVISOR_W-1:0] i_prem,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_divisor,
   output logic [DIVISOR_W-1:0] o_prem,
   output logic                 o_qbit
);

   // Shifted partial remainder needs one extra bit before the compare.
   logic [DIVISOR_W:0] w_shift;

   assign w_shift = {i_prem, i_bit};
   assign o_qbit  = (w_shift >= {1'b0, i_divisor});
   // When the divisor fits, the difference is < divisor so the low bits are exact.
   assign o_prem  = o_qbit ? (w_shift[DIVISOR_W-1:0] - i_divisor) : w_shift[DIVISOR_W-1:0];

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one quotient bit per cycle, divide-by-zero short path.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   state_e                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic [DIVIDEND_W-1:0] r_dq, w_dq_nxt;         // dividend shifts out MSB-first, quotient bits shift in at LSB
   logic [DIVISOR_W-1:0]  r_prem, w_prem_nxt;
   logic [DIVISOR_W-1:0]  r_dvs, w_dvs_nxt;
   logic [DIVIDEND_W-1:0] r_quo, w_quo_nxt;
   logic [DIVISOR_W-1:0]  r_rem, w_rem_nxt;
   logic                  r_dbz, w_dbz_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_done, w_done_nxt;

   logic [DIVISOR_W-1:0]  w_step_prem;
   logic                  w_step_qbit;

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_div_step (
      .i_prem    (r_prem),
      .i_bit     (r_dq[DIVIDEND_W-1]),
      .i_divisor (r_dvs),
      .o_prem    (w_step_prem),
      .o_qbit    (w_step_qbit)
   );

   // Next-state and datapath update selection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dq_nxt    = r_dq;
      w_prem_nxt  = r_prem;
      w_dvs_nxt   = r_dvs;
      w_quo_nxt   = r_quo;
      w_rem_nxt   = r_rem;
      w_dbz_nxt   = r_dbz;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_busy_nxt = 1'b1;
               if (divisor != '0) begin
                  w_dq_nxt    = dividend;
                  w_dvs_nxt   = divisor;
                  w_prem_nxt  = '0;
                  w_cnt_nxt   = CNT_W'(DIVIDEND_W - 1);
                  w_dbz_nxt   = 1'b0;
                  w_state_nxt = CALC;
               end else begin
                  w_quo_nxt   = '1;
                  w_rem_nxt   = dividend[DIVISOR_W-1:0];
                  w_dbz_nxt   = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end

         CALC: begin
            w_busy_nxt = 1'b1;
            w_dq_nxt   = {r_dq[DIVIDEND_W-2:0], w_step_qbit};
            w_prem_nxt = w_step_prem;
            w_cnt_nxt  = r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
               w_cnt_nxt   = '0;
               w_quo_nxt   = {r_dq[DIVIDEND_W-2:0], w_step_qbit};
               w_rem_nxt   = w_step_prem;
               w_done_nxt  = 1'b1;
               w_state_nxt = DONE;
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_dq    <= '0;
         r_prem  <= '0;
         r_dvs   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dq    <= w_dq_nxt;
         r_prem  <= w_prem_nxt;
         r_dvs   <= w_dvs_nxt;
         r_quo   <= w_quo_nxt;
         r_rem   <= w_rem_nxt;
         r_dbz   <= w_dbz_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quo;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule : seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter DIVIDEND_W, default 17, meaning dividend/quotient width (matches sum-of-products width).
REQ-002 The block SHALL have parameter DIVISOR_W, default 8, meaning divisor/remainder width (matches operand width).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, which is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, meaning request a divide; sampled only in IDLE.
REQ-006 The block SHALL have port dividend, input, DIVIDEND_W, unsigned, captured with start.
REQ-007 The block SHALL have port divisor, input, DIVISOR_W, unsigned, captured with start.
REQ-008 The block SHALL have port busy, output, 1, meaning high in CALC and DONE.
REQ-009 The block SHALL have port done, output, 1, meaning a one-cycle pulse when results are valid.
REQ-010 The block SHALL have port quotient, output, DIVIDEND_W, unsigned.
REQ-011 The block SHALL have port remainder, output, DIVISOR_W, unsigned.
REQ-012 The block SHALL have port div_by_zero, output, 1, meaning the last operation had divisor == 0.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE.
REQ-014 IDLE with start=1 and divisor!=0 SHALL capture the operands, clear the partial remainder, set the bit counter to DIVIDEND_W-1, clear div_by_zero, and go to CALC.
REQ-015 IDLE with start=1 and divisor==0 SHALL go directly to DONE with quotient = all ones, remainder = dividend[DIVISOR_W-1:0], and div_by_zero=1.
REQ-016 Each CALC cycle SHALL perform one restoring step: shift the next dividend MSB into the (DIVISOR_W+1)-bit partial remainder, subtract if >= divisor, and shift the result bit into the quotient.
REQ-017 CALC SHALL last exactly DIVIDEND_W cycles; the transition on counter == 0 goes to DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 Latency from the edge sampling start to the cycle with done=1 SHALL be DIVIDEND_W+1 cycles (18 by default), or 1 cycle for divide-by-zero.
REQ-020 quotient, remainder, and div_by_zero SHALL update only on completion and hold until the next completion.
REQ-021 start while busy=1 SHALL be ignored, with no queueing.
REQ-022 start in the DONE cycle SHALL be ignored; start in the cycle after DONE SHALL be accepted.
REQ-023 Operand inputs SHALL be don't-care after capture.
REQ-024 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for all divisor != 0.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter, at any state including mid-CALC.
REQ-026 An operation aborted by reset SHALL produce no done pulse, and start SHALL be ignored while rst=0.

Structure
REQ-027 A shared package SHALL hold the DIVIDEND_W/DIVISOR_W defaults, counter width (5), and the state encoding constants IDLE/CALC/DONE.
REQ-028 One combinational sub-module div_step SHALL be used: inputs are the partial remainder, the next dividend bit, and the divisor; outputs are the new partial remainder and the quotient bit.
REQ-029 The top level SHALL contain only the FSM, counter, operand/quotient shift registers, and output registers.

Verification
REQ-030 170/10 -> done 18 cycles after start, quotient=17, remainder=0, div_by_zero=0.
REQ-031 131071/255 -> quotient=514, remainder=1; 131071/1 -> quotient=131071, remainder=0.
REQ-032 100/200 -> quotient=0, remainder=100; then 5/0 -> done 1 cycle after start, quotient=131071, remainder=5, div_by_zero=1.
REQ-033 Issue 400/20, pulse start with 9/3 at cycle 5 -> only quotient=20, remainder=0 reported; 9/3 issued after done -> quotient=3, remainder=0.
REQ-034 Start 1000/7, assert rst=0 at cycle 8 -> all outputs 0, no done; after release, 1000/7 -> quotient=142, remainder=6.
REQ-035 Random 1000 operand pairs (including divisor 0) SHALL be checked against the REQ-024 identity by a scoreboard.
